// File: rtl/sequence_checker.sv
// Receive-side checker that locks onto the repeating 0,8,5,3,7,2 code, flags breaks and counts periods.
// Latency: every output is registered and reflects the sample taken on the same rising clock edge.
// Backpressure: none; valid qualifies each sample, and all state holds while valid is low.
module sequence_checker #(
    parameter int LOCK_LEN = 3,
    parameter int CNT_W    = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             valid,
    input  logic [3:0]       Yin,
    output logic             locked,
    output logic [3:0]       expected,
    output logic             cycle_done,
    output logic             error,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_LEN_C = 4'(LOCK_LEN);
    localparam logic [3:0] LAST_CODE  = 4'b0010;

    state_t           state_q, state_d;
    logic [3:0]       run_q, run_d;
    logic [3:0]       exp_q, exp_d;
    logic             cdone_q, cdone_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] ccnt_q, ccnt_d;
    logic [CNT_W-1:0] ecnt_q, ecnt_d;
    logic [3:0]       run_inc;

    // Membership in the six-code alphabet; everything else is noise.
    function automatic logic is_legal(input logic [3:0] v);
        case (v)
            4'h0, 4'h8, 4'h5, 4'h3, 4'h7, 4'h2: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    // Next code in the period; illegal inputs map to 0 but are never used that way.
    function automatic logic [3:0] succ(input logic [3:0] v);
        case (v)
            4'h0:    return 4'h8;
            4'h8:    return 4'h5;
            4'h5:    return 4'h3;
            4'h3:    return 4'h7;
            4'h7:    return 4'h2;
            default: return 4'h0;
        endcase
    endfunction

    assign run_inc = run_q + 4'd1;

    // Next-state and pulse logic; a mismatch while locked falls back through the HUNT entry rules.
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        exp_d   = exp_q;
        cdone_d = 1'b0;
        err_d   = 1'b0;
        ccnt_d  = ccnt_q;
        ecnt_d  = ecnt_q;
        if (valid) begin
            case (state_q)
                HUNT: begin
                    if (is_legal(Yin)) begin
                        state_d = SYNC;
                        run_d   = 4'd1;
                        exp_d   = succ(Yin);
                    end
                end
                SYNC: begin
                    if (Yin == exp_q) begin
                        run_d = run_inc;
                        exp_d = succ(Yin);
                        if (run_inc == LOCK_LEN_C) begin
                            state_d = LOCKED;
                        end
                    end else if (is_legal(Yin)) begin
                        run_d = 4'd1;
                        exp_d = succ(Yin);
                    end else begin
                        state_d = HUNT;
                        run_d   = 4'd0;
                        exp_d   = 4'd0;
                    end
                end
                LOCKED: begin
                    if (Yin == exp_q) begin
                        exp_d = succ(Yin);
                        if (Yin == LAST_CODE) begin
                            cdone_d = 1'b1;
                            ccnt_d  = (ccnt_q == '1) ? ccnt_q : ccnt_q + 1'b1;
                        end
                    end else begin
                        err_d  = 1'b1;
                        ecnt_d = (ecnt_q == '1) ? ecnt_q : ecnt_q + 1'b1;
                        if (is_legal(Yin)) begin
                            state_d = SYNC;
                            run_d   = 4'd1;
                            exp_d   = succ(Yin);
                        end else begin
                            state_d = HUNT;
                            run_d   = 4'd0;
                            exp_d   = 4'd0;
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                    run_d   = 4'd0;
                    exp_d   = 4'd0;
                end
            endcase
        end
    end

    // State and output registers; reset clears everything without waiting for a clock.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= HUNT;
            run_q   <= 4'd0;
            exp_q   <= 4'd0;
            cdone_q <= 1'b0;
            err_q   <= 1'b0;
            ccnt_q  <= '0;
            ecnt_q  <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            exp_q   <= exp_d;
            cdone_q <= cdone_d;
            err_q   <= err_d;
            ccnt_q  <= ccnt_d;
            ecnt_q  <= ecnt_d;
        end
    end

    assign locked      = (state_q == LOCKED);
    assign expected    = exp_q;
    assign cycle_done  = cdone_q;
    assign error       = err_q;
    assign cycle_count = ccnt_q;
    assign err_count   = ecnt_q;

endmodule

// File: tb/tb_sequence_checker.sv
// Bench for sequence_checker: a full-width instance and a 2-bit-counter instance share one stimulus stream.
// Latency: expectations are queued when a sample is driven and compared 1 ns after the sampling edge.
// Backpressure: none; valid gaps are part of the stimulus.
module tb_sequence_checker;

    localparam int LOCK_LEN = 3;

    logic       clock;
    logic       reset_n;
    logic       valid;
    logic [3:0] Yin;

    logic       locked, cycle_done, error;
    logic [3:0] expected;
    logic [7:0] cycle_count, err_count;

    logic       locked_s, cycle_done_s, error_s;
    logic [3:0] expected_s;
    logic [1:0] cycle_count_s, err_count_s;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       lk;
        logic [3:0] ex;
        logic       cd;
        logic       er;
        logic [7:0] cc;
        logic [7:0] ec;
        logic [1:0] cc2;
        logic [1:0] ec2;
    } exp_t;

    exp_t sb_q[$];
    exp_t sb_e;

    // Reference model state (independent of the RTL encoding).
    int         m_st;   // 0 hunt, 1 sync, 2 locked
    int         m_run;
    logic [3:0] m_exp;
    int         m_cc, m_ec, m_cc2, m_ec2;

    sequence_checker #(.LOCK_LEN(LOCK_LEN), .CNT_W(8)) dut (
        .clock(clock), .reset_n(reset_n), .valid(valid), .Yin(Yin),
        .locked(locked), .expected(expected), .cycle_done(cycle_done), .error(error),
        .cycle_count(cycle_count), .err_count(err_count)
    );

    sequence_checker #(.LOCK_LEN(LOCK_LEN), .CNT_W(2)) dut_s (
        .clock(clock), .reset_n(reset_n), .valid(valid), .Yin(Yin),
        .locked(locked_s), .expected(expected_s), .cycle_done(cycle_done_s), .error(error_s),
        .cycle_count(cycle_count_s), .err_count(err_count_s)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [3:0] code_at(input int i);
        case (i)
            0: return 4'h0;
            1: return 4'h8;
            2: return 4'h5;
            3: return 4'h3;
            4: return 4'h7;
            default: return 4'h2;
        endcase
    endfunction

    function automatic int pos_of(input logic [3:0] y);
        for (int i = 0; i < 6; i++) begin
            if (code_at(i) == y) return i;
        end
        return -1;
    endfunction

    function automatic logic [3:0] next_code(input logic [3:0] y);
        return code_at((pos_of(y) + 1) % 6);
    endfunction

    task automatic model_reset();
        m_st = 0; m_run = 0; m_exp = 4'h0;
        m_cc = 0; m_ec = 0; m_cc2 = 0; m_ec2 = 0;
        sb_q.delete();
    endtask

    task automatic model_step(input logic v, input logic [3:0] y);
        exp_t e;
        logic cd, er;
        cd = 1'b0;
        er = 1'b0;
        if (v) begin
            if (m_st == 0) begin
                if (pos_of(y) >= 0) begin m_st = 1; m_run = 1; m_exp = next_code(y); end
            end else if (m_st == 1) begin
                if (y == m_exp) begin
                    m_run = m_run + 1;
                    m_exp = next_code(y);
                    if (m_run >= LOCK_LEN) m_st = 2;
                end else if (pos_of(y) >= 0) begin
                    m_run = 1; m_exp = next_code(y);
                end else begin
                    m_st = 0; m_run = 0; m_exp = 4'h0;
                end
            end else begin
                if (y == m_exp) begin
                    m_exp = next_code(y);
                    if (y == 4'h2) begin
                        cd = 1'b1;
                        if (m_cc < 255) m_cc++;
                        if (m_cc2 < 3) m_cc2++;
                    end
                end else begin
                    er = 1'b1;
                    if (m_ec < 255) m_ec++;
                    if (m_ec2 < 3) m_ec2++;
                    if (pos_of(y) >= 0) begin m_st = 1; m_run = 1; m_exp = next_code(y); end
                    else begin m_st = 0; m_run = 0; m_exp = 4'h0; end
                end
            end
        end
        e.lk  = (m_st == 2);
        e.ex  = m_exp;
        e.cd  = cd;
        e.er  = er;
        e.cc  = 8'(m_cc);
        e.ec  = 8'(m_ec);
        e.cc2 = 2'(m_cc2);
        e.ec2 = 2'(m_ec2);
        sb_q.push_back(e);
    endtask

    // Drive one cycle at the falling edge, queue its expectation, return 2 ns after the sampling edge.
    task automatic drive(input logic v, input logic [3:0] y);
        @(negedge clock);
        valid = v;
        Yin   = y;
        model_step(v, y);
        @(posedge clock);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clock);
        valid   = 1'b0;
        reset_n = 1'b0;
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    // Scoreboard: pop one expectation per driven cycle and compare both instances.
    always @(posedge clock) begin
        #1;
        if (sb_q.size() > 0) begin
            sb_e = sb_q.pop_front();
            checks++;
            if (locked !== sb_e.lk || locked_s !== sb_e.lk) begin
                failures++;
                $display("FAIL sb_locked got=%0b/%0b want=%0b t=%0t", locked, locked_s, sb_e.lk, $time);
            end
            checks++;
            if (expected !== sb_e.ex || expected_s !== sb_e.ex) begin
                failures++;
                $display("FAIL sb_expected got=%0h/%0h want=%0h t=%0t", expected, expected_s, sb_e.ex, $time);
            end
            checks++;
            if (cycle_done !== sb_e.cd || cycle_done_s !== sb_e.cd) begin
                failures++;
                $display("FAIL sb_cycle_done got=%0b/%0b want=%0b t=%0t", cycle_done, cycle_done_s, sb_e.cd, $time);
            end
            checks++;
            if (error !== sb_e.er || error_s !== sb_e.er) begin
                failures++;
                $display("FAIL sb_error got=%0b/%0b want=%0b t=%0t", error, error_s, sb_e.er, $time);
            end
            checks++;
            if (cycle_count !== sb_e.cc || cycle_count_s !== sb_e.cc2) begin
                failures++;
                $display("FAIL sb_cycle_count got=%0d/%0d want=%0d/%0d t=%0t", cycle_count, cycle_count_s, sb_e.cc, sb_e.cc2, $time);
            end
            checks++;
            if (err_count !== sb_e.ec || err_count_s !== sb_e.ec2) begin
                failures++;
                $display("FAIL sb_err_count got=%0d/%0d want=%0d/%0d t=%0t", err_count, err_count_s, sb_e.ec, sb_e.ec2, $time);
            end
            checks++;
            if (cycle_done === 1'b1 && error === 1'b1) begin
                failures++;
                $display("FAIL sb_pulse_overlap cycle_done=1 error=1 want not both t=%0t", $time);
            end
        end
    end

    task automatic test_reset();
        #3;
        checks++;
        if ({locked, expected, cycle_done, error, cycle_count, err_count} !== 23'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%0h want=0", {locked, expected, cycle_done, error, cycle_count, err_count});
        end
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        checks++;
        if ({locked_s, expected_s, cycle_done_s, error_s, cycle_count_s, err_count_s} !== 11'd0) begin
            failures++;
            $display("FAIL reset_idle got=%0h want=0", {locked_s, expected_s, cycle_done_s, error_s, cycle_count_s, err_count_s});
        end
    endtask

    task automatic test_lock_and_count();
        logic [3:0] stream [12] = '{4'h0, 4'h8, 4'h5, 4'h3, 4'h7, 4'h2, 4'h0, 4'h8, 4'h5, 4'h3, 4'h7, 4'h2};
        int cd_seen = 0;
        int er_seen = 0;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, stream[i]);
            if (cycle_done === 1'b1) cd_seen++;
            if (error === 1'b1) er_seen++;
            if (i == 1) begin
                checks++;
                if (locked !== 1'b0) begin failures++; $display("FAIL lock_early got=%0b want=0", locked); end
            end
            if (i == 2) begin
                checks++;
                if (locked !== 1'b1) begin failures++; $display("FAIL lock_third got=%0b want=1", locked); end
            end
        end
        checks++;
        if (cd_seen != 2 || cycle_count !== 8'd2) begin
            failures++;
            $display("FAIL lock_count pulses=%0d count=%0d want=2/2", cd_seen, cycle_count);
        end
        checks++;
        if (er_seen != 0) begin failures++; $display("FAIL lock_no_error got=%0d want=0", er_seen); end
    endtask

    task automatic test_mid_entry();
        do_reset();
        drive(1'b1, 4'h7);
        drive(1'b1, 4'h2);
        checks++;
        if (locked !== 1'b0) begin failures++; $display("FAIL mid_not_yet got=%0b want=0", locked); end
        drive(1'b1, 4'h0);
        checks++;
        if (locked !== 1'b1) begin failures++; $display("FAIL mid_lock got=%0b want=1", locked); end
        drive(1'b1, 4'h8);
        checks++;
        if (expected !== 4'h5) begin failures++; $display("FAIL mid_expected got=%0h want=5", expected); end
    endtask

    task automatic test_break();
        do_reset();
        drive(1'b1, 4'h0);
        drive(1'b1, 4'h8);
        drive(1'b1, 4'h5);
        drive(1'b1, 4'h5);
        checks++;
        if (error !== 1'b1 || err_count !== 8'd1 || locked !== 1'b0 || expected !== 4'h3) begin
            failures++;
            $display("FAIL break_hit err=%0b cnt=%0d lk=%0b exp=%0h want 1/1/0/3", error, err_count, locked, expected);
        end
        drive(1'b1, 4'h3);
        checks++;
        if (error !== 1'b0 || locked !== 1'b0) begin
            failures++;
            $display("FAIL break_resync err=%0b lk=%0b want 0/0", error, locked);
        end
        drive(1'b1, 4'h7);
        checks++;
        if (locked !== 1'b1 || err_count !== 8'd1) begin
            failures++;
            $display("FAIL break_relock lk=%0b cnt=%0d want 1/1", locked, err_count);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        drive(1'b1, 4'h0);
        drive(1'b1, 4'hF);
        checks++;
        if (expected !== 4'h0 || error !== 1'b0 || err_count !== 8'd0) begin
            failures++;
            $display("FAIL illegal_hunt exp=%0h err=%0b cnt=%0d want 0/0/0", expected, error, err_count);
        end
        drive(1'b1, 4'h1);
        checks++;
        if (expected !== 4'h0) begin failures++; $display("FAIL illegal_ignored got=%0h want=0", expected); end
        drive(1'b1, 4'h0);
        checks++;
        if (expected !== 4'h8) begin failures++; $display("FAIL illegal_sync got=%0h want=8", expected); end
    endtask

    task automatic test_valid_gaps();
        do_reset();
        drive(1'b1, 4'h0);
        drive(1'b1, 4'h8);
        drive(1'b1, 4'h5);
        drive(1'b1, 4'h3);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 4'hF);
            checks++;
            if (locked !== 1'b1 || expected !== 4'h7 || cycle_done !== 1'b0 || error !== 1'b0) begin
                failures++;
                $display("FAIL gap_hold lk=%0b exp=%0h cd=%0b er=%0b want 1/7/0/0", locked, expected, cycle_done, error);
            end
        end
        drive(1'b1, 4'h7);
        drive(1'b1, 4'h2);
        checks++;
        if (cycle_done !== 1'b1 || cycle_count !== 8'd1) begin
            failures++;
            $display("FAIL gap_resume cd=%0b cnt=%0d want 1/1", cycle_done, cycle_count);
        end
        // Assert reset between edges and look before the next rising edge.
        #1;
        reset_n = 1'b0;
        valid   = 1'b0;
        model_reset();
        #1;
        checks++;
        if (locked !== 1'b0 || cycle_count !== 8'd0 || expected !== 4'h0 || cycle_done !== 1'b0) begin
            failures++;
            $display("FAIL async_reset lk=%0b cnt=%0d exp=%0h cd=%0b want 0/0/0/0", locked, cycle_count, expected, cycle_done);
        end
        @(negedge clock);
        reset_n = 1'b1;
        drive(1'b1, 4'h3);
        checks++;
        if (locked !== 1'b0 || expected !== 4'h7) begin
            failures++;
            $display("FAIL after_reset lk=%0b exp=%0h want 0/7", locked, expected);
        end
    endtask

    task automatic test_saturation();
        int cd_seen = 0;
        do_reset();
        for (int p = 0; p < 5; p++) begin
            for (int i = 0; i < 6; i++) begin
                drive(1'b1, code_at(i));
                if (cycle_done_s === 1'b1) cd_seen++;
            end
        end
        checks++;
        if (cd_seen != 5 || cycle_count_s !== 2'd3) begin
            failures++;
            $display("FAIL sat_cycle pulses=%0d count=%0d want 5/3", cd_seen, cycle_count_s);
        end
        checks++;
        if (cycle_count !== 8'd5) begin failures++; $display("FAIL sat_wide got=%0d want=5", cycle_count); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] last;
        logic [3:0] y;
        logic       v;
        do_reset();
        last = 4'h2;
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 9) < 8 && pos_of(last) >= 0) y = next_code(last);
            else y = 4'($urandom_range(0, 15));
            drive(v, y);
            if (v) last = y;
        end
        checks++;
        if (err_count === 8'd0) begin
            failures++;
            $display("FAIL b2b_errors_seen got=%0d want>0", err_count);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        valid   = 1'b0;
        Yin     = 4'h0;
        model_reset();
        test_reset();
        test_lock_and_count();
        test_mid_entry();
        test_break();
        test_illegal();
        test_valid_gaps();
        test_saturation();
        test_back_to_back();
        @(negedge clock);
        valid = 1'b0;
        repeat (3) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
